result_drain: RTL and testbench

- Downstream neighbour of the SIMD processor's result RAM.
- After a run completes, it reads num_rows wide rows (PE_ELEMENTS x DATA_WIDTH) from the result BRAM's second (read) port. Each row is serialised into DATA_WIDTH-bit words on a valid/ready output stream toward the host/DMA.
- It provides an FSM, row and word counters, BRAM-latency alignment and backpressure handling.

---
 rtl/simd_pkg.sv | 21 ++
 rtl/result_drain_if.sv | 30 +++
 rtl/result_drain.sv | 178 +++++++++++++++++
 tb/tb_result_drain.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared SIMD processor definitions.
// Holds the default datapath constants, the result-drain FSM state type and
// the packed result-row type used by both the processor result path and the
// result drain.
package simd_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int PE_ELEMENTS = 4;
  localparam int DRAM_DEPTH  = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    SEND = 2'd3
  } drain_state_t;

  // One result-RAM row; element 0 occupies the least significant bits.
  typedef logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] row_t;

endpackage

// File: rtl/result_drain_if.sv
// Word stream from the result drain toward the host/DMA.
// Ports (signals):
//   m_valid  word valid        (master -> slave)
//   m_ready  consumer ready    (slave  -> master)
//   m_data   DATA_WIDTH word   (master -> slave)
//   m_last   final word flag   (master -> slave)
interface result_drain_if #(
  parameter int DATA_WIDTH = simd_pkg::DATA_WIDTH
);

  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/result_drain.sv
// Result drain: after a processor run, reads num_rows rows from the result
// RAM read port (1-cycle latency) and serialises each row, element 0 first,
// onto a valid/ready word stream.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   start, num_rows      start pulse and row count (sampled only in IDLE)
//   ram_rd_en/addr/data  result-RAM read port
//   m_if                 output word stream (master side)
//   busy, done           activity flag and end-of-transfer pulse
// All outputs come straight from flops; their next values are derived from
// the next FSM state so they line up with the state they belong to.
module result_drain #(
  parameter  int DATA_WIDTH      = simd_pkg::DATA_WIDTH,
  parameter  int PE_ELEMENTS     = simd_pkg::PE_ELEMENTS,
  parameter  int DRAM_DEPTH      = simd_pkg::DRAM_DEPTH,
  localparam int DRAM_ADDR_WIDTH = $clog2(DRAM_DEPTH)
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              start,
  input  logic [DRAM_ADDR_WIDTH:0]          num_rows,
  output logic                              ram_rd_en,
  output logic [DRAM_ADDR_WIDTH-1:0]        ram_rd_addr,
  input  logic [PE_ELEMENTS*DATA_WIDTH-1:0] ram_rd_data,
  result_drain_if.master                    m_if,
  output logic                              busy,
  output logic                              done
);

  import simd_pkg::*;

  localparam int CNT_W  = DRAM_ADDR_WIDTH + 1;
  localparam int WIDX_W = (PE_ELEMENTS > 1) ? $clog2(PE_ELEMENTS) : 1;

  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(DRAM_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE_C   = CNT_W'(1);
  localparam logic [WIDX_W-1:0] WIDX_ZERO_C = {WIDX_W{1'b0}};
  localparam logic [WIDX_W-1:0] WIDX_ONE_C  = WIDX_W'(1);
  localparam logic [WIDX_W-1:0] WIDX_LAST_C = WIDX_W'(PE_ELEMENTS - 1);

  typedef logic [PE_ELEMENTS-1:0][DATA_WIDTH-1:0] drain_row_t;

  drain_state_t                 state_q,    state_d;
  logic [CNT_W-1:0]             row_cnt_q,  row_cnt_d;
  logic [CNT_W-1:0]             rows_lat_q, rows_lat_d;
  logic [WIDX_W-1:0]            word_idx_q, word_idx_d;
  drain_row_t                   row_buf_q,  row_buf_d;

  logic                         ram_rd_en_q,   ram_rd_en_d;
  logic [DRAM_ADDR_WIDTH-1:0]   ram_rd_addr_q, ram_rd_addr_d;
  logic                         m_valid_q,     m_valid_d;
  logic [DATA_WIDTH-1:0]        m_data_q,      m_data_d;
  logic                         m_last_q,      m_last_d;
  logic                         busy_q,        busy_d;
  logic                         done_q,        done_d;
  logic                         handshake;

  assign handshake = m_valid_q & m_if.m_ready;

  // FSM next state, row/word counters and row capture.
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    rows_lat_d = rows_lat_q;
    word_idx_d = word_idx_q;
    row_buf_d  = row_buf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_rows == CNT_ZERO_C) begin
            // Empty transfer: report completion without touching the RAM.
            done_d = 1'b1;
          end else begin
            rows_lat_d = (num_rows > DEPTH_C) ? DEPTH_C : num_rows;
            row_cnt_d  = CNT_ZERO_C;
            state_d    = RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        // Read data arrives one cycle after the RD-state read enable.
        row_buf_d  = drain_row_t'(ram_rd_data);
        word_idx_d = WIDX_ZERO_C;
        state_d    = SEND;
      end
      SEND: begin
        if (handshake) begin
          if (word_idx_q != WIDX_LAST_C) begin
            word_idx_d = word_idx_q + WIDX_ONE_C;
          end else if (row_cnt_q != (rows_lat_q - CNT_ONE_C)) begin
            row_cnt_d = row_cnt_q + CNT_ONE_C;
            state_d   = RD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output next values, decoded from the next state so the flopped outputs
  // are aligned with the state they describe.
  always_comb begin
    ram_rd_en_d   = (state_d == RD);
    ram_rd_addr_d = row_cnt_d[DRAM_ADDR_WIDTH-1:0];
    m_valid_d     = (state_d == SEND);
    busy_d        = (state_d != IDLE);
    if (state_d == SEND) begin
      // Serialiser mux; unchanged inputs while stalled keep the word stable.
      m_data_d = row_buf_d[word_idx_d];
      m_last_d = (word_idx_d == WIDX_LAST_C) &&
                 (row_cnt_d == (rows_lat_d - CNT_ONE_C));
    end else begin
      m_data_d = {DATA_WIDTH{1'b0}};
      m_last_d = 1'b0;
    end
  end

  // State, counter and row buffer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      row_cnt_q  <= CNT_ZERO_C;
      rows_lat_q <= CNT_ZERO_C;
      word_idx_q <= WIDX_ZERO_C;
      row_buf_q  <= {(PE_ELEMENTS*DATA_WIDTH){1'b0}};
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      rows_lat_q <= rows_lat_d;
      word_idx_q <= word_idx_d;
      row_buf_q  <= row_buf_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ram_rd_en_q   <= 1'b0;
      ram_rd_addr_q <= {DRAM_ADDR_WIDTH{1'b0}};
      m_valid_q     <= 1'b0;
      m_data_q      <= {DATA_WIDTH{1'b0}};
      m_last_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      ram_rd_en_q   <= ram_rd_en_d;
      ram_rd_addr_q <= ram_rd_addr_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_last_q      <= m_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign ram_rd_en    = ram_rd_en_q;
  assign ram_rd_addr  = ram_rd_addr_q;
  assign m_if.m_valid = m_valid_q;
  assign m_if.m_data  = m_data_q;
  assign m_if.m_last  = m_last_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: a queue-based model of the expected
// word stream, RAM read order, busy and done, checked every falling edge,
// plus directed scenarios with hand-computed literal expectations.
module tb_result_drain;

  localparam int DW    = 32;
  localparam int PE    = 4;
  localparam int DEPTH = 256;

  logic           clk;
  logic           rstn;
  logic           start;
  logic [8:0]     num_rows;
  logic           ram_rd_en;
  logic [7:0]     ram_rd_addr;
  logic [PE*DW-1:0] ram_rd_data;
  logic           busy;
  logic           done;

  result_drain_if #(.DATA_WIDTH(DW)) s_if ();

  result_drain #(
    .DATA_WIDTH (DW),
    .PE_ELEMENTS(PE),
    .DRAM_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .num_rows   (num_rows),
    .ram_rd_en  (ram_rd_en),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .m_if       (s_if),
    .busy       (busy),
    .done       (done)
  );

  simd_pkg::row_t ram [DEPTH];

  int n_chk  = 0;
  int n_fail = 0;

  // Model state (owned by the compare process).
  logic [31:0] exp_q[$];
  logic        model_busy = 1'b0;
  logic        exp_done   = 1'b0;
  int          exp_rd_row = 0;
  int          model_rows = 0;
  int          acc_cnt    = 0;
  int          last_at    = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b1;
  logic [31:0] prev_data  = 32'd0;
  logic        prev_last  = 1'b0;

  // RAM-side bookkeeping (owned by the RAM process).
  int          rd_cnt       = 0;
  int          last_rd_addr = -1;

  logic        ready_mode = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Result RAM with 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_rd_en) begin
      ram_rd_data  <= ram[ram_rd_addr];
      rd_cnt       <= rd_cnt + 1;
      last_rd_addr <= int'(ram_rd_addr);
    end
  end

  // Consumer ready: always ready, or a pseudo-random 50% pattern.
  initial begin
    s_if.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      s_if.m_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: model of the transfer checked on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_q.delete();
        model_busy = 1'b0;
        exp_done   = 1'b0;
        exp_rd_row = 0;
        model_rows = 0;
        prev_valid = 1'b0;
        prev_ready = 1'b1;
      end else begin
        chk("done", 64'(done), 64'(exp_done));
        chk("busy", 64'(busy), 64'(model_busy));
        if (ram_rd_en) begin
          chk("rd_addr", 64'(ram_rd_addr), 64'(exp_rd_row));
          chk("rd_in_range", 64'(exp_rd_row < model_rows), 64'd1);
          exp_rd_row++;
        end
        if (prev_valid && !prev_ready) begin
          chk("stall_valid", 64'(s_if.m_valid), 64'd1);
          chk("stall_data", 64'(s_if.m_data), 64'(prev_data));
          chk("stall_last", 64'(s_if.m_last), 64'(prev_last));
        end
        if (s_if.m_valid) begin
          if (exp_q.size() == 0) begin
            chk("extra_word", 64'd1, 64'd0);
          end else begin
            chk("m_data", 64'(s_if.m_data), 64'(exp_q[0]));
            chk("m_last", 64'(s_if.m_last), 64'(exp_q.size() == 1));
          end
        end
        // Advance the model to what must be visible after the next edge.
        exp_done = 1'b0;
        if (start && !model_busy) begin
          if (num_rows == 9'd0) begin
            exp_done = 1'b1;
          end else begin
            model_rows = (int'(num_rows) > DEPTH) ? DEPTH : int'(num_rows);
            exp_rd_row = 0;
            model_busy = 1'b1;
            for (int r = 0; r < model_rows; r++) begin
              for (int e = 0; e < PE; e++) begin
                exp_q.push_back(ram[r][e]);
              end
            end
          end
        end
        if (s_if.m_valid && s_if.m_ready && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          acc_cnt++;
          if (s_if.m_last) last_at = acc_cnt;
          if (exp_q.size() == 0) begin
            exp_done   = 1'b1;
            model_busy = 1'b0;
          end
        end
        prev_valid = s_if.m_valid;
        prev_ready = s_if.m_ready;
        prev_data  = s_if.m_data;
        prev_last  = s_if.m_last;
      end
    end
  end

  task automatic do_start(input int n);
    @(posedge clk);
    #1;
    start    = 1'b1;
    num_rows = 9'(n);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_acc(input int target, input int budget);
    int c;
    c = 0;
    while (acc_cnt < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (acc_cnt < target) chk("acc_timeout", 64'(acc_cnt), 64'(target));
  endtask

  int a0, r0, lat;

  initial begin
    for (int r = 0; r < DEPTH; r++)
      for (int e = 0; e < PE; e++)
        ram[r][e] = 32'(r * PE + e + 1);
    rstn     = 1'b0;
    start    = 1'b0;
    num_rows = 9'd0;
    #12;
    chk("rst_valid", 64'(s_if.m_valid), 64'd0);
    chk("rst_last",  64'(s_if.m_last),  64'd0);
    chk("rst_data",  64'(s_if.m_data),  64'd0);
    chk("rst_rd_en", 64'(ram_rd_en),    64'd0);
    chk("rst_addr",  64'(ram_rd_addr),  64'd0);
    chk("rst_busy",  64'(busy),         64'd0);
    chk("rst_done",  64'(done),         64'd0);
    @(negedge clk);
    #2;
    rstn = 1'b1;

    // 1: two rows, always ready.
    a0 = acc_cnt; r0 = rd_cnt;
    do_start(2);
    lat = 1;
    while (!s_if.m_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("first_valid_latency", 64'(lat), 64'd3);
    chk("first_word", 64'(s_if.m_data), 64'd1);
    wait_done(100);
    chk("t1_words", 64'(acc_cnt - a0), 64'd8);
    chk("t1_reads", 64'(rd_cnt - r0), 64'd2);
    chk("t1_last_addr", 64'(last_rd_addr), 64'd1);
    chk("t1_last_pos", 64'(last_at - a0), 64'd8);

    // 2: same data, random backpressure.
    ready_mode = 1'b1;
    a0 = acc_cnt;
    do_start(2);
    wait_done(400);
    chk("t2_words", 64'(acc_cnt - a0), 64'd8);
    ready_mode = 1'b0;

    // 3: zero rows.
    a0 = acc_cnt; r0 = rd_cnt;
    do_start(0);
    chk("t3_done", 64'(done), 64'd1);
    wait_done(10);
    @(posedge clk);
    #1;
    chk("t3_done_once", 64'(done), 64'd0);
    chk("t3_words", 64'(acc_cnt - a0), 64'd0);
    chk("t3_reads", 64'(rd_cnt - r0), 64'd0);

    // 4: start while busy is ignored; then a 5-row transfer.
    a0 = acc_cnt;
    do_start(2);
    wait_acc(a0 + 3, 100);
    do_start(5);
    wait_done(100);
    chk("t4_words", 64'(acc_cnt - a0), 64'd8);
    a0 = acc_cnt;
    do_start(5);
    wait_done(200);
    chk("t4_words_new", 64'(acc_cnt - a0), 64'd20);

    // 5: reset while sending word 3 of row 0.
    a0 = acc_cnt;
    do_start(2);
    wait_acc(a0 + 2, 100);
    @(posedge clk);
    #1;
    chk("t5_pre_word3", 64'(s_if.m_data), 64'd3);
    rstn = 1'b0;
    #1;
    chk("t5_valid_drop", 64'(s_if.m_valid), 64'd0);
    chk("t5_busy_drop",  64'(busy),         64'd0);
    chk("t5_rd_en_drop", 64'(ram_rd_en),    64'd0);
    chk("t5_no_done",    64'(done),         64'd0);
    @(negedge clk);
    #2;
    rstn = 1'b1;
    a0 = acc_cnt;
    do_start(1);
    wait_done(100);
    chk("t5_words", 64'(acc_cnt - a0), 64'd4);

    // 6: saturation at DRAM_DEPTH.
    a0 = acc_cnt; r0 = rd_cnt;
    do_start(300);
    wait_done(3000);
    chk("t6_words", 64'(acc_cnt - a0), 64'd1024);
    chk("t6_reads", 64'(rd_cnt - r0), 64'd256);
    chk("t6_last_addr", 64'(last_rd_addr), 64'd255);
    chk("t6_last_pos", 64'(last_at - a0), 64'd1024);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
